// File: rtl/la_rstseq_pkg.sv
// Shared definitions for the multi-channel reset sequencer:
// FSM state encoding and a width helper that never returns zero.
package la_rstseq_pkg;

  localparam logic [1:0] ENC_ASSERT  = 2'd0;
  localparam logic [1:0] ENC_HOLD    = 2'd1;
  localparam logic [1:0] ENC_RELEASE = 2'd2;
  localparam logic [1:0] ENC_RUN     = 2'd3;

  typedef enum logic [1:0] {
    ST_ASSERT  = ENC_ASSERT,
    ST_HOLD    = ENC_HOLD,
    ST_RELEASE = ENC_RELEASE,
    ST_RUN     = ENC_RUN
  } state_t;

  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/la_dsync.sv
// STAGES-deep single-bit synchronizer; synchronous reset clears every stage to 0.
module la_dsync #(
  parameter string PROP   = "DEFAULT",
  parameter int    STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Non-default hints keep the chain in its own scope so a tech flow can swap in hardened cells.
  if (PROP == "DEFAULT") begin : g_generic
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[STAGES-2:0], d};
    end
  end else begin : g_tech
    always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/la_rstseq.sv
// Multi-channel reset sequencer: synchronizes active-low requests, holds all outputs
// in reset while any is active, then releases channels in order, channel 0 first.
module la_rstseq
  import la_rstseq_pkg::*;
#(
  parameter string PROP   = "DEFAULT",
  parameter int    N      = 4,
  parameter int    STAGES = 2,
  parameter int    HOLD   = 16,
  parameter int    GAP    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] nreq_in,
  input  logic         force_reset,
  output logic [N-1:0] nrst_out,
  output logic         busy,
  output logic         done
);

  localparam int CW = clog2w(((HOLD > GAP) ? HOLD : GAP) + 1);
  localparam int IW = clog2w(N);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  logic [N-1:0]  nreq_sync;
  logic          req_ok;
  logic          do_rel;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  for (genvar i = 0; i < N; i++) begin : g_sync
    la_dsync #(.PROP(PROP), .STAGES(STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (nreq_in[i]),
      .q   (nreq_sync[i])
    );
  end

  assign req_ok = &nreq_sync;

  // A release step happens either straight out of ASSERT (no hold), at the end of HOLD, or every GAP in RELEASE.
  always_comb begin
    do_rel = 1'b0;
    case (state)
      ST_ASSERT:  do_rel = (HOLD == 0);
      ST_HOLD:    do_rel = (cnt == HOLD_LAST);
      ST_RELEASE: do_rel = (cnt == GAP_LAST);
      default:    do_rel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !req_ok || force_reset) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      idx      <= '0;
      nrst_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (do_rel) begin
      nrst_out <= nrst_out | (N'(1) << idx);
      cnt      <= '0;
      if (idx == IDX_LAST) begin
        state <= ST_RUN;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= ST_RELEASE;
        idx   <= idx + 1'b1;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        ST_ASSERT: begin
          state <= ST_HOLD;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        ST_HOLD, ST_RELEASE: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
